// File: rtl/arbiter_puf_32.sv
// Behavioural 4-XOR arbiter PUF: an LFSR challenge drives four additive-delay
// arbiter chains. The XOR of the four decisions shifts into a 32-bit response word.

module arbiter_puf_32_chain #(
    parameter int          K      = 0,
    parameter logic [7:0]  W_SEED = 8'hA5
) (
    input  logic [31:0] neg_i,   // neg_i[i] = 1 when phi[i] = -1
    output logic        r_o
);
    // Stage weights are elaboration-time constants; only the sign select is live logic.
    function automatic logic signed [15:0] weight(input int i);
        logic [7:0] b;
        b = W_SEED ^ 8'((59 * i + 101 * (K + 1)) % 256);
        return {{8{b[7]}}, b};
    endfunction

    logic signed [15:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (neg_i[i]) acc = acc - weight(i);
            else          acc = acc + weight(i);
        end
        r_o = (acc > 16'sd0);
    end
endmodule

module arbiter_puf_32 #(
    parameter logic [31:0] CHAL_SEED = 32'h0000_0001,
    parameter logic [7:0]  W_SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] c_bits,
    output logic        mkg1,
    output logic        mkg2,
    output logic        mkg3,
    output logic        mkg4,
    output logic [31:0] puf_output
);
    // An all-zero LFSR state would lock up, so a zero seed falls back to 1.
    localparam logic [31:0] SEED_EFF = (CHAL_SEED == 32'h0) ? 32'h0000_0001 : CHAL_SEED;

    logic [31:0] chal_q, chal_d;
    logic [31:0] resp_q, resp_d;
    logic [3:0]  mkg_q,  mkg_d;
    logic [31:0] neg;
    logic [3:0]  r;
    logic        par;

    // Suffix parity: neg[i] is the parity of chal_q[31:i].
    always_comb begin
        par = 1'b0;
        neg = '0;
        for (int i = 31; i >= 0; i--) begin
            par    = par ^ chal_q[i];
            neg[i] = par;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chain
        arbiter_puf_32_chain #(.K(k), .W_SEED(W_SEED)) u_chain (
            .neg_i (neg),
            .r_o   (r[k])
        );
    end

    always_comb begin
        chal_d = {chal_q[30:0], chal_q[31] ^ chal_q[21] ^ chal_q[1] ^ chal_q[0]};
        resp_d = {resp_q[30:0], ^r};
        mkg_d  = r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chal_q <= SEED_EFF;
            resp_q <= '0;
            mkg_q  <= '0;
        end else begin
            chal_q <= chal_d;
            resp_q <= resp_d;
            mkg_q  <= mkg_d;
        end
    end

    assign c_bits     = chal_q;
    assign puf_output = resp_q;
    assign mkg1       = mkg_q[0];
    assign mkg2       = mkg_q[1];
    assign mkg3       = mkg_q[2];
    assign mkg4       = mkg_q[3];
endmodule

// File: tb/tb_arbiter_puf_32.sv
// Directed bench for arbiter_puf_32: reset values, LFSR sequence, arbiter decisions
// against an independent delay model, response shifting, zero seed and mid-stream reset.

module tb_arbiter_puf_32;
    logic        clk;
    logic        rst;
    logic [31:0] c0, c1, p0, p1;
    logic        a1, a2, a3, a4;
    logic        b1, b2, b3, b4;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mc;      // model challenge
    logic [31:0] mresp;   // model response word
    logic [3:0]  exp_r;
    logic [31:0] lfsr_tbl [3];

    arbiter_puf_32 u_dut (
        .clk(clk), .rst(rst), .c_bits(c0),
        .mkg1(a1), .mkg2(a2), .mkg3(a3), .mkg4(a4), .puf_output(p0)
    );

    arbiter_puf_32 #(.CHAL_SEED(32'h0)) u_zero (
        .clk(clk), .rst(rst), .c_bits(c1),
        .mkg1(b1), .mkg2(b2), .mkg3(b3), .mkg4(b4), .puf_output(p1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Additive delay model written from the weight formula and parity definition.
    function automatic int model_delta(input int k, input logic [31:0] c);
        int          s;
        int          w;
        int          ones;
        logic [7:0]  wb;
        logic [31:0] sh;
        s = 0;
        for (int i = 0; i < 32; i++) begin
            wb   = 8'hA5 ^ 8'((59 * i + 101 * (k + 1)) % 256);
            w    = (wb >= 8'd128) ? int'(wb) - 256 : int'(wb);
            sh   = c >> i;
            ones = $countones(sh);
            s    = s + (((ones % 2) == 0) ? w : -w);
        end
        return s;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] c);
        return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_c_bits"},  c0, 32'h0000_0001);
        chk({tag, "_c_zero"},  c1, 32'h0000_0001);
        chk({tag, "_mkg"},     {28'h0, a4, a3, a2, a1}, 32'h0);
        chk({tag, "_mkg_z"},   {28'h0, b4, b3, b2, b1}, 32'h0);
        chk({tag, "_puf"},     p0, 32'h0);
        chk({tag, "_puf_z"},   p1, 32'h0);
    endtask

    // Called at a negedge with rst high; each iteration checks the state after one edge.
    task automatic run_cycles(input int n, input string tag);
        for (int cyc = 0; cyc < n; cyc++) begin
            for (int k = 0; k < 4; k++) exp_r[k] = (model_delta(k, mc) > 0);
            @(posedge clk);
            mc    = lfsr_next(mc);
            mresp = {mresp[30:0], ^exp_r};
            @(negedge clk);
            if (cyc < 3) chk({tag, "_lfsr_const"}, c0, lfsr_tbl[cyc]);
            chk({tag, "_c_bits"}, c0, mc);
            chk({tag, "_c_zero"}, c1, mc);
            chk({tag, "_mkg"},    {28'h0, a4, a3, a2, a1}, {28'h0, exp_r});
            chk({tag, "_puf"},    p0, mresp);
            chk({tag, "_puf_z"},  p1, mresp);
        end
    endtask

    initial begin
        lfsr_tbl[0] = 32'h0000_0003;
        lfsr_tbl[1] = 32'h0000_0006;
        lfsr_tbl[2] = 32'h0000_000D;

        rst = 1'b1;
        #2 rst = 1'b0;
        #100;
        chk_reset("reset_hold");

        @(negedge clk);
        rst   = 1'b1;
        mc    = 32'h0000_0001;
        mresp = 32'h0;
        run_cycles(50, "run1");

        // Asynchronous assertion between edges must clear outputs without a clock.
        #5 rst = 1'b0;
        #1 chk_reset("async_rst");
        repeat (3) @(negedge clk);
        chk_reset("rst_held");

        rst   = 1'b1;
        mc    = 32'h0000_0001;
        mresp = 32'h0;
        run_cycles(1100, "run2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
